// File: rtl/seq_det_pkg.sv
// ============================================================================
// seq_det_pkg : shared types, default sizes and config checks for seq_det_ctrl
// Revision    : 1.0
// ============================================================================
`default_nettype none

package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_WIN_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2,
    ST_TMO    = 2'd3
  } state_t;

  function automatic logic pat_len_ok(input logic [3:0] len, input int max_len);
    return (len != 4'd0) && (32'(len) <= max_len);
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_det_match.sv
// ============================================================================
// seq_det_match : serial shift register, fill counter and length-masked compare
// Build option  : SEQ_DET_OVERLAP_EN keeps the fill count across a match
// Revision      : 1.0
// ============================================================================
`default_nettype none

module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [3:0]         pat_len,
  output logic               match
);

  localparam int                FILL_W   = $clog2(MAX_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(MAX_LEN);

  // Only MAX_LEN-1 history bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] sh;
  logic [MAX_LEN-1:0] sh_next;
  logic [MAX_LEN-1:0] len_mask;
  logic [FILL_W-1:0]  fill;
  logic [FILL_W-1:0]  fill_next;

  always_comb begin
    sh_next   = {sh, x};
    fill_next = (fill == FILL_MAX) ? fill : fill + 1'b1;
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(pat_len));
    end
    match = shift_en
         && (32'(fill_next) >= 32'(pat_len))
         && (((sh_next ^ pattern) & len_mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sh   <= '0;
      fill <= '0;
    end else if (shift_en) begin
      sh <= sh_next[MAX_LEN-2:0];
`ifdef SEQ_DET_OVERLAP_EN
      fill <= fill_next;
`else
      fill <= match ? '0 : fill_next;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_det_ctrl.sv
// ============================================================================
// seq_det_ctrl : programmable serial-pattern detection controller
// Build option : SEQ_DET_OVERLAP_EN allows overlapping matches
// Revision     : 1.0
// ============================================================================
`default_nettype none

module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int WIN_W   = DEF_WIN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [3:0]         pat_len,
  input  logic [CNT_W-1:0]   target,
  input  logic [WIN_W-1:0]   window,
  output logic               busy,
  output logic               hit,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               timeout,
  output logic               cfg_err
);

  state_t             state;
  state_t             state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [3:0]         len_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [WIN_W-1:0]   win_q;
  logic [WIN_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WIN_W-1:0]   bit_inc;
  logic               cfg_ok;
  logic               accept;
  logic               reject;
  logic               sampling;
  logic               match;
  logic               reach;
  logic               expire;
  logic               busy_d;
  logic               hit_d;
  logic               done_d;
  logic               timeout_d;
  logic               cfg_err_d;

  assign cfg_ok   = pat_len_ok(pat_len, MAX_LEN) && (target != '0);
  assign accept   = (state == ST_IDLE) && start && cfg_ok;
  assign reject   = (state == ST_IDLE) && start && !cfg_ok;
  assign sampling = (state == ST_SEARCH) && !abort;
  assign cnt_inc  = match_cnt + 1'b1;
  assign bit_inc  = bit_cnt + 1'b1;
  assign reach    = match && (cnt_inc == tgt_q);
  // Reaching the target on the final window bit takes priority over expiry.
  assign expire   = sampling && (win_q != '0) && (bit_inc == win_q) && !reach;

  seq_det_match #(
    .MAX_LEN (MAX_LEN)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .shift_en (sampling),
    .x        (x),
    .pattern  (pat_q),
    .pat_len  (len_q),
    .match    (match)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      hit     <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_d;
      busy    <= busy_d;
      hit     <= hit_d;
      done    <= done_d;
      timeout <= timeout_d;
      cfg_err <= cfg_err_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (accept) state_d = ST_SEARCH;
      ST_SEARCH: begin
        if (abort)       state_d = ST_IDLE;
        else if (reach)  state_d = ST_DONE;
        else if (expire) state_d = ST_TMO;
      end
      ST_DONE:   state_d = ST_IDLE;
      ST_TMO:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d    = (state_d == ST_SEARCH);
    hit_d     = match;
    done_d    = reach;
    timeout_d = expire;
    cfg_err_d = reject;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      tgt_q     <= '0;
      win_q     <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
    end else if (accept) begin
      pat_q     <= pattern;
      len_q     <= pat_len;
      tgt_q     <= target;
      win_q     <= window;
      bit_cnt   <= '0;
      match_cnt <= '0;
    end else if (sampling) begin
      bit_cnt <= bit_inc;
      if (match) match_cnt <= cnt_inc;
    end
  end

endmodule

`default_nettype wire

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Programmable serial-pattern detection controller.
- Software arms it with a bit pattern (1..MAX_LEN bits), a required match count and an optional sample window.
- It then samples one serial bit per clock, counts pattern matches, and ends the run with a single-cycle done or timeout pulse.
- Generalises the fixed hard-wired sequence detectors; those become one configuration of this block.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits.
- CNT_W, 8, width of the match target and match counter.
- WIN_W, 16, width of the sample-window limit and bit counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  arm request; honoured only in IDLE.
- abort  in  1  cancel the active run; honoured only in SEARCH.
- x  in  1  serial data bit; sampled at every rising edge while in SEARCH.
- pattern  in  MAX_LEN  target bits; pattern[pat_len-1] is the earliest received bit, pattern[0] the latest.
- pat_len  in  4  pattern length; valid range 1..MAX_LEN.
- target  in  CNT_W  matches required for done; valid range >=1.
- window  in  WIN_W  maximum bits to sample; 0 = unlimited.
- busy  out  1  high only in SEARCH.
- hit  out  1  one-cycle pulse per detected match.
- match_cnt  out  CNT_W  matches counted in current/last run.
- done  out  1  one-cycle pulse when target is reached.
- timeout  out  1  one-cycle pulse when window expires first.
- cfg_err  out  1  one-cycle pulse on rejected start.

Behaviour:
- Reset: state=IDLE. shift register, fill counter, bit counter and match_cnt = 0. busy, hit, done, timeout and cfg_err = 0. Latched configuration is cleared to 0.
- Reset mid-run: returns to IDLE immediately. No done or timeout pulse is generated.
- States are IDLE, SEARCH, DONE and TMO. All outputs are registered.
- IDLE, start=1 at edge N:
  - If pat_len==0, pat_len>MAX_LEN or target==0: cfg_err=1 in cycle N+1, state stays IDLE, nothing else changes.
  - Otherwise: latch pattern, pat_len, target and window. Clear shift register, fill counter, bit counter and match_cnt. Enter SEARCH in cycle N+1.
- SEARCH, every edge:
  - Shift x in (sh <= {sh[MAX_LEN-2:0], x}).
  - Fill counter increments, saturating at MAX_LEN.
  - Bit counter increments.
- Match condition: fill >= pat_len AND the low pat_len bits of the updated shift register equal the low pat_len bits of the latched pattern.
- On a match at edge N: hit=1 in cycle N+1 and match_cnt increments in N+1.
- match_cnt reaches target at edge N: state=DONE in N+1, done=1, busy=0. Next cycle goes to IDLE.
- Window expiry: window!=0 and the updated bit count == window, with target not reached at edge N. Then state=TMO in N+1, timeout=1, busy=0. Next cycle goes to IDLE.
- Final match on the last window bit: done wins. No timeout pulse.
- abort in SEARCH: next state is IDLE. No done, timeout or hit for that edge's sample. match_cnt is retained.
- start in SEARCH, DONE or TMO: ignored.
- start and abort together in IDLE: start wins.
- match_cnt is held after done, timeout or abort until the next accepted start.
- Configuration inputs are don't-care except at the accepted start edge.

Optional Feature:
- Macro: SEQ_DET_OVERLAP_EN.
- Defined: matches may overlap. The fill counter is not cleared on a match, so the suffix of one match can begin the next.
- Undefined: the fill counter is cleared to 0 on each match. The next match needs pat_len fresh bits.
- Both variants keep identical ports and timing.

Decomposition:
- Package seq_det_pkg holds:
  - state typedef (IDLE, SEARCH, DONE, TMO);
  - default constants for MAX_LEN, CNT_W and WIN_W;
  - pat_len validity check function.
- Sub-module seq_det_match holds the shift register, fill counter and masked length-variable compare. It outputs a combinational match flag to the controller FSM.

Test Plan:
- Pattern 6'b111010, pat_len=6, target=1, window=0; x=1,1,1,0,1,0 -> hit and done in the cycle after the 6th bit; match_cnt=1; busy falls the same cycle.
- Pattern 3'b101, pat_len=3, target=2; x=1,0,1,0,1:
  - with SEQ_DET_OVERLAP_EN: done after the 5th bit;
  - without it: only 1 hit by the 5th bit; x=1,0,1 more -> done after the 8th bit.
- Pattern 2'b11, target=1, window=4; x=0,0,0,0 -> timeout after the 4th bit; match_cnt=0; no hit, no done.
- Pattern 6'b111010, target=1, window=6; x=1,1,1,0,1,0 -> done=1, timeout never asserts.
- start with pat_len=0 -> cfg_err pulse one cycle later; busy stays 0. Repeat with target=0 -> same.
- Valid start, 3 bits sampled, then abort=1 -> IDLE next cycle with no done or timeout. Separately, rst asserted mid-SEARCH -> all outputs 0 next cycle. A start during SEARCH is ignored: match_cnt is not cleared.
